// File: rtl/multi_alarm_set_if.sv
// Button, field-select and time inputs plus display/alarm outputs of multi_alarm_set.
// master drives the inputs (controller or bench); slave is the alarm block.
interface multi_alarm_set_if #(
    parameter int N_ALM = 4,
    parameter int SEL_W = 2
);
    logic             U;
    logic             D;
    logic [3:0]       COUNT;
    logic [3:0]       OPTION;
    logic [SEL_W-1:0] SEL;
    logic [6:0]       CUR_HOUR;
    logic [6:0]       CUR_MIN;
    logic             ACK;
    logic [6:0]       HOUR_A;
    logic [6:0]       MIN_A;
    logic [N_ALM-1:0] EN_A;
    logic [N_ALM-1:0] ALARM_HIT;
    logic             RING;

    modport master (
        output U, D, COUNT, OPTION, SEL, CUR_HOUR, CUR_MIN, ACK,
        input  HOUR_A, MIN_A, EN_A, ALARM_HIT, RING
    );

    modport slave (
        input  U, D, COUNT, OPTION, SEL, CUR_HOUR, CUR_MIN, ACK,
        output HOUR_A, MIN_A, EN_A, ALARM_HIT, RING
    );
endinterface

// File: rtl/multi_alarm_set.sv
// Multi-channel alarm: button-driven hour/minute/enable editing with auto-repeat,
// per-channel match detection producing one-cycle hits and a sticky RING flag.
module multi_alarm_set #(
    parameter int N_ALM   = 4,
    parameter int SEL_W   = 2,
    parameter int RPT_DLY = 500,
    parameter int RPT_PER = 100
) (
    input logic              CLK,
    input logic              RESETN,
    multi_alarm_set_if.slave bus
);

    localparam logic [3:0] FIELD_HOUR = 4'b0010;
    localparam logic [3:0] FIELD_MIN  = 4'b0001;
    localparam logic [3:0] FIELD_EN   = 4'b0100;
    localparam logic [3:0] OPT_EDIT   = 4'b0001;
    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MIN_MAX    = 7'd59;
    localparam int HOLD_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        HOLD_IDLE,
        HOLD_DELAY,
        HOLD_REPEAT
    } hold_state_e;

    logic             u_last_q, u_last_d;
    logic             d_last_q, d_last_d;
    logic             u_arm_q, u_arm_d;
    logic             d_arm_q, d_arm_d;
    logic [SEL_W-1:0] sel_last_q, sel_last_d;
    logic [3:0]       count_last_q, count_last_d;
    logic [3:0]       option_last_q, option_last_d;

    hold_state_e      hold_state_q, hold_state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_up_q, hold_up_d;

    logic             step_q, step_d;
    logic             step_up_q, step_up_d;
    logic             step_rpt_q, step_rpt_d;

    logic [6:0]       hour_q [N_ALM];
    logic [6:0]       hour_d [N_ALM];
    logic [6:0]       min_q  [N_ALM];
    logic [6:0]       min_d  [N_ALM];
    logic [N_ALM-1:0] en_q, en_d;
    logic [N_ALM-1:0] match_q, match_d;
    logic [N_ALM-1:0] hit_q, hit_d;
    logic             ring_q, ring_d;

    logic press_u, press_d, both_held, ctx_change, still_held, rpt_due;

    function automatic logic [6:0] step_val(input logic [6:0] v, input logic [6:0] vmax,
                                            input logic up);
        if (up) begin
            return (v >= vmax) ? 7'd0 : v + 7'd1;
        end
        return (v == 7'd0 || v > vmax) ? vmax : v - 7'd1;
    endfunction

    // Arm flags keep a button held through reset from counting as a fresh press.
    always_comb begin
        u_last_d      = bus.U;
        d_last_d      = bus.D;
        u_arm_d       = u_arm_q | ~bus.U;
        d_arm_d       = d_arm_q | ~bus.D;
        sel_last_d    = bus.SEL;
        count_last_d  = bus.COUNT;
        option_last_d = bus.OPTION;

        both_held  = bus.U & bus.D;
        press_u    = bus.U & ~u_last_q & u_arm_q & ~bus.D;
        press_d    = bus.D & ~d_last_q & d_arm_q & ~bus.U;
        ctx_change = (bus.SEL != sel_last_q) | (bus.COUNT != count_last_q) |
                     (bus.OPTION != option_last_q);
        still_held = (hold_up_q ? bus.U : bus.D) & ~both_held & ~ctx_change;
        rpt_due    = ((hold_state_q == HOLD_DELAY)  && (hold_cnt_q == HOLD_W'(RPT_DLY))) ||
                     ((hold_state_q == HOLD_REPEAT) && (hold_cnt_q == HOLD_W'(RPT_PER)));
    end

    // Hold counter value k in the cycle before edge k after the press step,
    // so a step fires exactly RPT_DLY (then RPT_PER) edges after the previous one.
    always_comb begin
        hold_state_d = hold_state_q;
        hold_cnt_d   = hold_cnt_q;
        hold_up_d    = hold_up_q;
        step_d       = 1'b0;
        step_up_d    = hold_up_q;
        step_rpt_d   = 1'b0;
        if (press_u || press_d) begin
            hold_state_d = HOLD_DELAY;
            hold_cnt_d   = HOLD_W'(1);
            hold_up_d    = press_u;
            step_d       = 1'b1;
            step_up_d    = press_u;
        end else if (hold_state_q != HOLD_IDLE && still_held) begin
            if (rpt_due) begin
                hold_state_d = HOLD_REPEAT;
                hold_cnt_d   = HOLD_W'(1);
                step_d       = 1'b1;
                step_rpt_d   = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end else begin
            hold_state_d = HOLD_IDLE;
            hold_cnt_d   = '0;
        end
    end

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        en_d   = en_q;
        if (step_q && bus.OPTION == OPT_EDIT) begin
            for (int unsigned i = 0; i < N_ALM; i++) begin
                if (bus.SEL == SEL_W'(i)) begin
                    case (bus.COUNT)
                        FIELD_HOUR: hour_d[i] = step_val(hour_q[i], HOUR_MAX, step_up_q);
                        FIELD_MIN:  min_d[i]  = step_val(min_q[i], MIN_MAX, step_up_q);
                        FIELD_EN:   if (!step_rpt_q) en_d[i] = ~en_q[i];
                        default:    ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        match_d = '0;
        for (int unsigned i = 0; i < N_ALM; i++) begin
            match_d[i] = en_q[i] & (bus.CUR_HOUR == hour_q[i]) & (bus.CUR_MIN == min_q[i]);
        end
        hit_d  = match_d & ~match_q;
        ring_d = ring_q;
        if (bus.ACK) ring_d = 1'b0;
        if (|hit_q)  ring_d = 1'b1;
    end

    always_comb begin
        bus.HOUR_A = '0;
        bus.MIN_A  = '0;
        for (int unsigned i = 0; i < N_ALM; i++) begin
            if (bus.SEL == SEL_W'(i)) begin
                bus.HOUR_A = hour_q[i];
                bus.MIN_A  = min_q[i];
            end
        end
    end

    assign bus.EN_A      = en_q;
    assign bus.ALARM_HIT = hit_q;
    assign bus.RING      = ring_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            u_last_q      <= 1'b0;
            d_last_q      <= 1'b0;
            u_arm_q       <= 1'b0;
            d_arm_q       <= 1'b0;
            sel_last_q    <= '0;
            count_last_q  <= '0;
            option_last_q <= '0;
            hold_state_q  <= HOLD_IDLE;
            hold_cnt_q    <= '0;
            hold_up_q     <= 1'b0;
            step_q        <= 1'b0;
            step_up_q     <= 1'b0;
            step_rpt_q    <= 1'b0;
            for (int unsigned i = 0; i < N_ALM; i++) begin
                hour_q[i] <= '0;
                min_q[i]  <= '0;
            end
            en_q          <= '0;
            match_q       <= '0;
            hit_q         <= '0;
            ring_q        <= 1'b0;
        end else begin
            u_last_q      <= u_last_d;
            d_last_q      <= d_last_d;
            u_arm_q       <= u_arm_d;
            d_arm_q       <= d_arm_d;
            sel_last_q    <= sel_last_d;
            count_last_q  <= count_last_d;
            option_last_q <= option_last_d;
            hold_state_q  <= hold_state_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_up_q     <= hold_up_d;
            step_q        <= step_d;
            step_up_q     <= step_up_d;
            step_rpt_q    <= step_rpt_d;
            hour_q        <= hour_d;
            min_q         <= min_d;
            en_q          <= en_d;
            match_q       <= match_d;
            hit_q         <= hit_d;
            ring_q        <= ring_d;
        end
    end

endmodule

// File: tb/tb_multi_alarm_set.sv
// Directed bench for multi_alarm_set: a 4-channel instance with short repeat timing,
// and a 3-channel instance sharing its inputs for out-of-range SEL behaviour.
module tb_multi_alarm_set;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    multi_alarm_set_if #(.N_ALM(4), .SEL_W(2)) ifc_a ();
    multi_alarm_set_if #(.N_ALM(3), .SEL_W(2)) ifc_b ();

    assign ifc_b.U        = ifc_a.U;
    assign ifc_b.D        = ifc_a.D;
    assign ifc_b.COUNT    = ifc_a.COUNT;
    assign ifc_b.OPTION   = ifc_a.OPTION;
    assign ifc_b.SEL      = ifc_a.SEL;
    assign ifc_b.CUR_HOUR = ifc_a.CUR_HOUR;
    assign ifc_b.CUR_MIN  = ifc_a.CUR_MIN;
    assign ifc_b.ACK      = ifc_a.ACK;

    multi_alarm_set #(.N_ALM(4), .SEL_W(2), .RPT_DLY(4), .RPT_PER(2)) dut_a (
        .CLK(clk), .RESETN(rstn), .bus(ifc_a)
    );
    multi_alarm_set #(.N_ALM(3), .SEL_W(2), .RPT_DLY(4), .RPT_PER(2)) dut_b (
        .CLK(clk), .RESETN(rstn), .bus(ifc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up);
        if (up) ifc_a.U = 1'b1; else ifc_a.D = 1'b1;
        tick();
        ifc_a.U = 1'b0;
        ifc_a.D = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        total++;
        if (ifc_a.HOUR_A !== 7'd0 || ifc_a.MIN_A !== 7'd0) begin
            bad++; $display("FAIL reset_time got=%0d:%0d want=0:0", ifc_a.HOUR_A, ifc_a.MIN_A);
        end
        total++;
        if (ifc_a.EN_A !== 4'b0 || ifc_a.ALARM_HIT !== 4'b0 || ifc_a.RING !== 1'b0) begin
            bad++; $display("FAIL reset_flags got en=%b hit=%b ring=%b want 0", ifc_a.EN_A,
                            ifc_a.ALARM_HIT, ifc_a.RING);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_hour_step();
        logic [6:0] want;
        ifc_a.OPTION = 4'b0001;
        ifc_a.COUNT  = 4'b0010;
        ifc_a.SEL    = 2'd1;
        tick();
        ifc_a.U = 1'b1;
        tick();
        total++;
        if (ifc_a.HOUR_A !== 7'd0) begin
            bad++; $display("FAIL hour_latency got=%0d want=0", ifc_a.HOUR_A);
        end
        ifc_a.U = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            ifc_a.SEL = 2'(c);
            #1;
            want = (c == 1) ? 7'd1 : 7'd0;
            total++;
            if (ifc_a.HOUR_A !== want || ifc_a.MIN_A !== 7'd0) begin
                bad++; $display("FAIL hour_step ch%0d got=%0d:%0d want=%0d:0", c, ifc_a.HOUR_A,
                                ifc_a.MIN_A, want);
            end
        end
    endtask

    task automatic test_wrap();
        ifc_a.SEL   = 2'd0;
        ifc_a.COUNT = 4'b0010;
        press(1'b0);
        total++;
        if (ifc_a.HOUR_A !== 7'd23) begin
            bad++; $display("FAIL hour_down_wrap got=%0d want=23", ifc_a.HOUR_A);
        end
        press(1'b1);
        total++;
        if (ifc_a.HOUR_A !== 7'd0) begin
            bad++; $display("FAIL hour_up_wrap got=%0d want=0", ifc_a.HOUR_A);
        end
        ifc_a.COUNT = 4'b0001;
        press(1'b0);
        total++;
        if (ifc_a.MIN_A !== 7'd59) begin
            bad++; $display("FAIL min_down_wrap got=%0d want=59", ifc_a.MIN_A);
        end
        press(1'b1);
        total++;
        if (ifc_a.MIN_A !== 7'd0) begin
            bad++; $display("FAIL min_up_wrap got=%0d want=0", ifc_a.MIN_A);
        end
    endtask

    task automatic test_repeat();
        logic [6:0] want_min [10];
        want_min = '{7'd0, 7'd1, 7'd1, 7'd1, 7'd1, 7'd2, 7'd2, 7'd3, 7'd3, 7'd4};
        ifc_a.SEL   = 2'd0;
        ifc_a.COUNT = 4'b0001;
        tick();
        ifc_a.U = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (ifc_a.MIN_A !== want_min[k]) begin
                bad++; $display("FAIL repeat_t%0d got=%0d want=%0d", k + 1, ifc_a.MIN_A,
                                want_min[k]);
            end
        end
        ifc_a.U = 1'b0;
        tick();
        tick();
        total++;
        if (ifc_a.MIN_A !== 7'd4) begin
            bad++; $display("FAIL repeat_release got=%0d want=4", ifc_a.MIN_A);
        end
        ifc_a.U = 1'b1;
        ifc_a.D = 1'b1;
        repeat (8) tick();
        ifc_a.D = 1'b0;
        repeat (4) tick();
        ifc_a.U = 1'b0;
        tick();
        tick();
        total++;
        if (ifc_a.MIN_A !== 7'd4) begin
            bad++; $display("FAIL both_buttons got=%0d want=4", ifc_a.MIN_A);
        end
    endtask

    task automatic test_alarm();
        ifc_a.SEL   = 2'd2;
        ifc_a.COUNT = 4'b0010;
        repeat (7) press(1'b1);
        ifc_a.COUNT = 4'b0001;
        repeat (30) press(1'b1);
        total++;
        if (ifc_a.HOUR_A !== 7'd7 || ifc_a.MIN_A !== 7'd30) begin
            bad++; $display("FAIL alarm_setup got=%0d:%0d want=7:30", ifc_a.HOUR_A, ifc_a.MIN_A);
        end
        ifc_a.COUNT = 4'b0100;
        press(1'b1);
        total++;
        if (ifc_a.EN_A !== 4'b0100) begin
            bad++; $display("FAIL enable_toggle got=%b want=0100", ifc_a.EN_A);
        end
        ifc_a.CUR_HOUR = 7'd7;
        ifc_a.CUR_MIN  = 7'd29;
        tick();
        tick();
        total++;
        if (ifc_a.ALARM_HIT !== 4'b0 || ifc_a.RING !== 1'b0) begin
            bad++; $display("FAIL pre_match got hit=%b ring=%b want 0000/0", ifc_a.ALARM_HIT,
                            ifc_a.RING);
        end
        ifc_a.CUR_MIN = 7'd30;
        tick();
        total++;
        if (ifc_a.ALARM_HIT !== 4'b0100 || ifc_a.RING !== 1'b0) begin
            bad++; $display("FAIL hit_edge got hit=%b ring=%b want 0100/0", ifc_a.ALARM_HIT,
                            ifc_a.RING);
        end
        tick();
        total++;
        if (ifc_a.ALARM_HIT !== 4'b0 || ifc_a.RING !== 1'b1) begin
            bad++; $display("FAIL ring_set got hit=%b ring=%b want 0000/1", ifc_a.ALARM_HIT,
                            ifc_a.RING);
        end
        repeat (3) tick();
        total++;
        if (ifc_a.ALARM_HIT !== 4'b0 || ifc_a.RING !== 1'b1) begin
            bad++; $display("FAIL hold_match got hit=%b ring=%b want 0000/1", ifc_a.ALARM_HIT,
                            ifc_a.RING);
        end
        ifc_a.ACK = 1'b1;
        tick();
        ifc_a.ACK = 1'b0;
        total++;
        if (ifc_a.RING !== 1'b0) begin
            bad++; $display("FAIL ack_clear got=%b want=0", ifc_a.RING);
        end
        press(1'b1);
        press(1'b1);
        tick();
        total++;
        if (ifc_a.ALARM_HIT !== 4'b0100) begin
            bad++; $display("FAIL edit_hit got=%b want=0100", ifc_a.ALARM_HIT);
        end
        ifc_a.ACK = 1'b1;
        tick();
        total++;
        if (ifc_a.RING !== 1'b1) begin
            bad++; $display("FAIL set_beats_ack got=%b want=1", ifc_a.RING);
        end
        tick();
        ifc_a.ACK = 1'b0;
        total++;
        if (ifc_a.RING !== 1'b0) begin
            bad++; $display("FAIL ack_after_set got=%b want=0", ifc_a.RING);
        end
        ifc_a.U = 1'b1;
        repeat (8) tick();
        ifc_a.U = 1'b0;
        tick();
        tick();
        total++;
        if (ifc_a.EN_A !== 4'b0000) begin
            bad++; $display("FAIL repeat_no_toggle got=%b want=0000", ifc_a.EN_A);
        end
        ifc_a.CUR_HOUR = 7'd99;
        ifc_a.CUR_MIN  = 7'd99;
    endtask

    task automatic test_gate();
        ifc_a.SEL    = 2'd0;
        ifc_a.COUNT  = 4'b0010;
        ifc_a.OPTION = 4'b0000;
        press(1'b1);
        total++;
        if (ifc_a.HOUR_A !== 7'd0) begin
            bad++; $display("FAIL option_gate got=%0d want=0", ifc_a.HOUR_A);
        end
        ifc_a.OPTION = 4'b0001;
        ifc_a.SEL    = 2'd3;
        press(1'b1);
        total++;
        if (ifc_a.HOUR_A !== 7'd1) begin
            bad++; $display("FAIL ch3_edit got=%0d want=1", ifc_a.HOUR_A);
        end
        total++;
        if (ifc_b.HOUR_A !== 7'd0 || ifc_b.MIN_A !== 7'd0) begin
            bad++; $display("FAIL sel_oob_mux got=%0d:%0d want=0:0", ifc_b.HOUR_A, ifc_b.MIN_A);
        end
        ifc_a.SEL = 2'd2;
        #1;
        total++;
        if (ifc_b.HOUR_A !== 7'd7 || ifc_b.MIN_A !== 7'd30) begin
            bad++; $display("FAIL oob_ch2_kept got=%0d:%0d want=7:30", ifc_b.HOUR_A, ifc_b.MIN_A);
        end
        ifc_a.SEL = 2'd1;
        #1;
        total++;
        if (ifc_b.HOUR_A !== 7'd1 || ifc_b.MIN_A !== 7'd0) begin
            bad++; $display("FAIL oob_ch1_kept got=%0d:%0d want=1:0", ifc_b.HOUR_A, ifc_b.MIN_A);
        end
        ifc_a.SEL = 2'd0;
        #1;
        total++;
        if (ifc_b.HOUR_A !== 7'd0 || ifc_b.MIN_A !== 7'd4) begin
            bad++; $display("FAIL oob_ch0_kept got=%0d:%0d want=0:4", ifc_b.HOUR_A, ifc_b.MIN_A);
        end
    endtask

    task automatic test_reset_held();
        ifc_a.SEL   = 2'd0;
        ifc_a.COUNT = 4'b0001;
        tick();
        ifc_a.U = 1'b1;
        repeat (7) tick();
        total++;
        if (ifc_a.MIN_A !== 7'd6) begin
            bad++; $display("FAIL pre_reset_repeat got=%0d want=6", ifc_a.MIN_A);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        total++;
        if (ifc_a.HOUR_A !== 7'd0 || ifc_a.MIN_A !== 7'd0 || ifc_a.EN_A !== 4'b0 ||
            ifc_a.ALARM_HIT !== 4'b0 || ifc_a.RING !== 1'b0) begin
            bad++; $display("FAIL held_reset got=%0d:%0d en=%b hit=%b ring=%b want all 0",
                            ifc_a.HOUR_A, ifc_a.MIN_A, ifc_a.EN_A, ifc_a.ALARM_HIT, ifc_a.RING);
        end
        repeat (8) tick();
        total++;
        if (ifc_a.MIN_A !== 7'd0) begin
            bad++; $display("FAIL held_no_press got=%0d want=0", ifc_a.MIN_A);
        end
        ifc_a.U = 1'b0;
        tick();
        press(1'b1);
        total++;
        if (ifc_a.MIN_A !== 7'd1) begin
            bad++; $display("FAIL repress_after_reset got=%0d want=1", ifc_a.MIN_A);
        end
        ifc_a.SEL = 2'd2;
        #1;
        total++;
        if (ifc_a.HOUR_A !== 7'd0 || ifc_a.MIN_A !== 7'd0) begin
            bad++; $display("FAIL reset_ch2 got=%0d:%0d want=0:0", ifc_a.HOUR_A, ifc_a.MIN_A);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rstn           = 1'b0;
        ifc_a.U        = 1'b0;
        ifc_a.D        = 1'b0;
        ifc_a.COUNT    = 4'b0000;
        ifc_a.OPTION   = 4'b0000;
        ifc_a.SEL      = 2'd0;
        ifc_a.CUR_HOUR = 7'd99;
        ifc_a.CUR_MIN  = 7'd99;
        ifc_a.ACK      = 1'b0;
        test_reset();
        test_hour_step();
        test_wrap();
        test_repeat();
        test_alarm();
        test_gate();
        test_reset_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
